ps2_led_command_sequencer: RTL and testbench

- Sits directly upstream of the PS/2 command transmitter stage and drives its the_command/send_command handshake.
- Updates keyboard LEDs with the two-byte sequence 0xED followed by the LED mask.
- Waits for the keyboard's 0xFA acknowledge after each byte, using the received-byte stream from the PS/2 data-in stage.
- Resends on 0xFE, ack timeout or transmitter error, up to a retry limit; queues one pending update while busy.

---
 rtl/ps2_led_command_sequencer_if.sv | 27 ++
 rtl/ps2_led_command_sequencer.sv | 167 ++++++++++++++++
 tb/tb_ps2_led_command_sequencer.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_led_command_sequencer_if.sv
// rtl/ps2_led_command_sequencer_if.sv - PS/2 transmitter handshake and receive-byte stream bundle
interface ps2_led_command_sequencer_if;
  logic [7:0] the_command;
  logic       send_command;
  logic       command_was_sent;
  logic       error_communication_timed_out;
  logic [7:0] received_data;
  logic       received_data_en;

  modport master (
    output the_command,
    output send_command,
    input  command_was_sent,
    input  error_communication_timed_out,
    input  received_data,
    input  received_data_en
  );

  modport slave (
    input  the_command,
    input  send_command,
    output command_was_sent,
    output error_communication_timed_out,
    output received_data,
    output received_data_en
  );
endinterface

// File: rtl/ps2_led_command_sequencer.sv
// rtl/ps2_led_command_sequencer.sv - sends 0xED + LED mask to a PS/2 keyboard with ack, retry and one queued update
module ps2_led_command_sequencer #(
  parameter int CLOCK          = 100,
  parameter int ACK_TIMEOUT_US = 20000,
  parameter int MAX_RETRIES    = 3
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [2:0]                         led_state,
  input  logic                               led_update,
  ps2_led_command_sequencer_if.master        ps2,
  output logic                               busy,
  output logic                               done,
  output logic                               error,
  output logic [2:0]                         led_sent
);

  localparam int unsigned TIMEOUT_CYCLES = CLOCK * ACK_TIMEOUT_US;
  localparam int CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RETRY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_IDLE, S_SEND, S_REL_OK, S_REL_ERR, S_WAIT_ACK, S_RETRY, S_DONE, S_FAIL
  } state_t;

  state_t             state_q, state_d;
  logic               byte_idx_q, byte_idx_d;
  logic [RETRY_W-1:0] retries_q, retries_d;
  logic [2:0]         led_latched_q, led_latched_d;
  logic               pending_q, pending_d;
  logic [2:0]         pending_led_q, pending_led_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               early_q, early_d;
  logic [7:0]         early_data_q, early_data_d;
  logic [7:0]         the_command_q, the_command_d;
  logic               send_command_q, send_command_d;
  logic [2:0]         led_sent_q, led_sent_d;

  logic               resp_valid;
  logic [7:0]         resp_data;

  // A byte that arrived while the transmitter was still releasing is consumed first.
  assign resp_valid = early_q | ps2.received_data_en;
  assign resp_data  = early_q ? early_data_q : ps2.received_data;

  always_comb begin
    state_d        = state_q;
    byte_idx_d     = byte_idx_q;
    retries_d      = retries_q;
    led_latched_d  = led_latched_q;
    pending_d      = pending_q;
    pending_led_d  = pending_led_q;
    cnt_d          = '0;
    early_d        = 1'b0;
    early_data_d   = early_data_q;
    the_command_d  = the_command_q;
    send_command_d = (state_q == S_SEND);
    led_sent_d     = led_sent_q;

    if (led_update && (state_q != S_IDLE)) begin
      pending_d     = 1'b1;
      pending_led_d = led_state;
    end

    unique case (state_q)
      S_IDLE: begin
        if (led_update || pending_q) begin
          state_d       = S_SEND;
          led_latched_d = led_update ? led_state : pending_led_q;
          byte_idx_d    = 1'b0;
          retries_d     = '0;
          pending_d     = 1'b0;
        end
      end
      S_SEND: begin
        the_command_d = byte_idx_q ? {5'b0, led_latched_q} : 8'hED;
        if (ps2.error_communication_timed_out) begin
          state_d = S_REL_ERR;
        end else if (ps2.command_was_sent) begin
          state_d = S_REL_OK;
        end
      end
      S_REL_OK: begin
        early_d = early_q | ps2.received_data_en;
        if (ps2.received_data_en) begin
          early_data_d = ps2.received_data;
        end
        if (!ps2.command_was_sent && !ps2.error_communication_timed_out) begin
          state_d = S_WAIT_ACK;
        end
      end
      S_REL_ERR: begin
        if (!ps2.command_was_sent && !ps2.error_communication_timed_out) begin
          state_d = S_RETRY;
        end
      end
      S_WAIT_ACK: begin
        cnt_d = cnt_q + 1'b1;
        if (resp_valid && (resp_data == 8'hFA)) begin
          if (!byte_idx_q) begin
            byte_idx_d = 1'b1;
            retries_d  = '0;
            state_d    = S_SEND;
          end else begin
            led_sent_d = led_latched_q;
            state_d    = S_DONE;
          end
        end else if (resp_valid && (resp_data == 8'hFE)) begin
          state_d = S_RETRY;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = S_RETRY;
        end
      end
      S_RETRY: begin
        if (retries_q == RETRY_LIMIT) begin
          state_d = S_FAIL;
        end else begin
          retries_d = retries_q + 1'b1;
          state_d   = S_SEND;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_FAIL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      byte_idx_q     <= 1'b0;
      retries_q      <= '0;
      led_latched_q  <= 3'b000;
      pending_q      <= 1'b0;
      pending_led_q  <= 3'b000;
      cnt_q          <= '0;
      early_q        <= 1'b0;
      early_data_q   <= 8'h00;
      the_command_q  <= 8'h00;
      send_command_q <= 1'b0;
      led_sent_q     <= 3'b000;
    end else begin
      state_q        <= state_d;
      byte_idx_q     <= byte_idx_d;
      retries_q      <= retries_d;
      led_latched_q  <= led_latched_d;
      pending_q      <= pending_d;
      pending_led_q  <= pending_led_d;
      cnt_q          <= cnt_d;
      early_q        <= early_d;
      early_data_q   <= early_data_d;
      the_command_q  <= the_command_d;
      send_command_q <= send_command_d;
      led_sent_q     <= led_sent_d;
    end
  end

  assign ps2.the_command  = the_command_q;
  assign ps2.send_command = send_command_q;
  assign busy             = (state_q != S_IDLE);
  assign done             = (state_q == S_DONE);
  assign error            = (state_q == S_FAIL);
  assign led_sent         = led_sent_q;

endmodule

// File: tb/tb_ps2_led_command_sequencer.sv
// tb/tb_ps2_led_command_sequencer.sv - directed and randomized bench with a transaction-level keyboard model
module tb_ps2_led_command_sequencer;

  localparam int CLOCK   = 1;
  localparam int TMO_US  = 50;
  localparam int MAXR    = 3;
  localparam int LIMIT   = CLOCK * TMO_US;
  localparam int O_ACK   = 0;
  localparam int O_NAK   = 1;
  localparam int O_TMO   = 2;
  localparam int O_TXERR = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] led_state = 3'b000;
  logic       led_update = 1'b0;
  logic       busy, done, error;
  logic [2:0] led_sent;
  logic       tx_fail = 1'b0;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int exp_done = 0;
  int exp_err = 0;
  logic [2:0] m_led_sent = 3'b000;
  int script_q[$];
  logic [2:0] inject_q[$];

  ps2_led_command_sequencer_if bus ();

  ps2_led_command_sequencer #(
    .CLOCK(CLOCK), .ACK_TIMEOUT_US(TMO_US), .MAX_RETRIES(MAXR)
  ) dut (
    .clk(clk), .reset(reset), .led_state(led_state), .led_update(led_update),
    .ps2(bus.master), .busy(busy), .done(done), .error(error), .led_sent(led_sent)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (done === 1'b1) done_cnt++;
    if (error === 1'b1) err_cnt++;
  end

  // Transmitter: reports its result half a cycle after the request, holds it until the request drops.
  always @(negedge clk) begin
    if (bus.send_command === 1'b1) begin
      if (!bus.command_was_sent && !bus.error_communication_timed_out) begin
        if (tx_fail) bus.error_communication_timed_out = 1'b1;
        else         bus.command_was_sent = 1'b1;
      end
    end else begin
      bus.command_was_sent = 1'b0;
      bus.error_communication_timed_out = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_level(input logic lvl, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (bus.send_command === lvl) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic pulse_upd(input logic [2:0] led);
    led_state  = led;
    led_update = 1'b1;
    @(negedge clk);
    led_update = 1'b0;
  endtask

  task automatic pulse_rx(input logic [7:0] b);
    bus.received_data    = b;
    bus.received_data_en = 1'b1;
    @(negedge clk);
    bus.received_data_en = 1'b0;
  endtask

  // One LED update seen as a list of byte transmissions; each gets an outcome and the
  // model decides which byte must come next and how the sequence ends.
  task automatic do_seq(input logic [2:0] led, input bit pulse, input bit rnd);
    int idx = 0;
    int retries = 0;
    int outcome;
    int prev_outcome = -1;
    int last_rise = 0;
    int unsigned r;
    bit ok;
    bit fin = 1'b0;
    logic [7:0] exp_byte;
    logic [7:0] junk;
    if (pulse) pulse_upd(led);
    while (!fin) begin
      if (script_q.size() > 0) outcome = script_q.pop_front();
      else if (rnd) begin
        r = $urandom_range(0, 9);
        outcome = (r < 5) ? O_ACK : (r < 7) ? O_NAK : (r < 8) ? O_TMO : O_TXERR;
      end else outcome = O_ACK;
      tx_fail = (outcome == O_TXERR);
      wait_level(1'b1, ok);
      chk("send_rise", 32'(ok), 32'd1);
      if (!ok) return;
      exp_byte = (idx != 0) ? {5'b0, led} : 8'hED;
      chk("the_command", 32'(bus.the_command), 32'(exp_byte));
      // Zero-latency transmitter: 2 cycles in SEND, 2 releasing, the timeout, 1 in RETRY.
      if (prev_outcome == O_TMO) chk("retry_spacing", 32'(cyc - last_rise), 32'(LIMIT + 5));
      last_rise = cyc;
      prev_outcome = outcome;
      while (inject_q.size() > 0) pulse_upd(inject_q.pop_front());
      wait_level(1'b0, ok);
      chk("send_fall", 32'(ok), 32'd1);
      if (!ok) return;
      tx_fail = 1'b0;
      if (outcome == O_ACK || outcome == O_NAK) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        if (outcome == O_ACK && rnd && ($urandom_range(0, 1) == 1)) begin
          junk = 8'($urandom_range(0, 255));
          if (junk == 8'hFA || junk == 8'hFE) junk = 8'h3C;
          pulse_rx(junk);
          @(negedge clk);
        end
        pulse_rx((outcome == O_ACK) ? 8'hFA : 8'hFE);
      end
      if (outcome == O_ACK) begin
        if (idx == 0) begin
          idx = 1;
          retries = 0;
        end else begin
          exp_done++;
          m_led_sent = led;
          fin = 1'b1;
        end
      end else if (retries == MAXR) begin
        exp_err++;
        fin = 1'b1;
      end else begin
        retries++;
      end
    end
    for (int i = 0; i < 300 && !(done_cnt == exp_done && err_cnt == exp_err); i++) @(negedge clk);
    @(negedge clk);
    chk("done_count", 32'(done_cnt), 32'(exp_done));
    chk("error_count", 32'(err_cnt), 32'(exp_err));
    chk("led_sent", 32'(led_sent), 32'(m_led_sent));
  endtask

  initial begin
    logic [2:0] pend_led;
    logic [2:0] led;
    bit have_pend;
    bit pulse;
    bit ok;
    bit seen_busy;
    bus.received_data    = 8'h00;
    bus.received_data_en = 1'b0;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_the_command", 32'(bus.the_command), 32'h00);
    chk("rst_send_command", 32'(bus.send_command), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_led_sent", 32'(led_sent), 32'd0);

    // Silent keyboard: four 0xED attempts, then one error, led_sent untouched.
    repeat (4) script_q.push_back(O_TMO);
    do_seq(3'b011, 1'b1, 1'b0);

    script_q = '{O_ACK, O_ACK};
    do_seq(3'b101, 1'b1, 1'b0);
    chk("idle_after_done", 32'(busy), 32'd0);

    script_q = '{O_NAK, O_ACK, O_ACK};
    do_seq(3'b110, 1'b1, 1'b0);

    // Transmitter error on the mask byte resends the mask, not 0xED.
    script_q = '{O_ACK, O_TXERR, O_ACK};
    do_seq(3'b101, 1'b1, 1'b0);

    // Two updates while busy: only the last one is serviced afterwards.
    script_q = '{O_ACK, O_ACK};
    inject_q = '{3'b001, 3'b010};
    do_seq(3'b100, 1'b1, 1'b0);
    script_q = '{O_ACK, O_ACK};
    do_seq(3'b010, 1'b0, 1'b0);
    chk("idle_after_pending", 32'(busy), 32'd0);

    have_pend = 1'b0;
    pend_led  = 3'b000;
    for (int s = 0; s < 30; s++) begin
      led   = have_pend ? pend_led : 3'($urandom_range(0, 7));
      pulse = !have_pend;
      have_pend = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        pend_led = 3'($urandom_range(0, 7));
        inject_q.push_back(pend_led);
        have_pend = 1'b1;
      end
      do_seq(led, pulse, 1'b1);
    end
    if (have_pend) do_seq(pend_led, 1'b0, 1'b1);
    repeat (3) @(negedge clk);

    // Reset while waiting for the acknowledge, with an update already queued.
    pulse_upd(3'b011);
    wait_level(1'b1, ok);
    chk("rst_seq_rise", 32'(ok), 32'd1);
    wait_level(1'b0, ok);
    chk("rst_seq_fall", 32'(ok), 32'd1);
    repeat (3) @(negedge clk);
    pulse_upd(3'b110);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_led_sent = 3'b000;
    chk("midrst_send_command", 32'(bus.send_command), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    pulse_rx(8'hFA);
    seen_busy = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (busy === 1'b1) seen_busy = 1'b1;
      @(negedge clk);
    end
    chk("midrst_no_restart", 32'(seen_busy), 32'd0);
    chk("midrst_done_count", 32'(done_cnt), 32'(exp_done));
    chk("midrst_error_count", 32'(err_cnt), 32'(exp_err));
    chk("midrst_led_sent", 32'(led_sent), 32'(m_led_sent));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
